// File: rtl/lcd_ctrl.sv
// Purpose: turns CPU writes to the LCD register into timed HD44780-style write cycles, with autonomous power-up init.
// Latency: a write strobed at edge N drives RS/DATA at edge N+1 (if idle) and raises EN at edge N+1+T_SU.
// Backpressure: one pending slot; a write arriving while the slot is full is dropped and flagged in sticky o_ovf.
module lcd_ctrl #(
    parameter int unsigned T_PWRUP     = 750000,
    parameter int unsigned T_SU        = 4,
    parameter int unsigned T_EN        = 12,
    parameter int unsigned T_HOLD      = 2,
    parameter int unsigned T_EXEC      = 1850,
    parameter int unsigned T_EXEC_LONG = 76000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_lcd_we,
    input  logic [31:0] i_lcd_wdata,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_init_done,
    output logic        o_ovf
);

    // Contents of the single pending-write slot.
    typedef struct packed {
        logic       on;
        logic       rs;
        logic [7:0] data;
    } pend_t;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    // Every phase counts up from zero and ends when the counter reaches its limit.
    localparam logic [CNT_W-1:0] LIM_PWRUP = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] LIM_SU    = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] LIM_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LIM_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LIM_EXEC  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LIM_LONG  = CNT_W'(T_EXEC_LONG - 1);

    localparam logic [2:0] INIT_LEN = 3'd4;

    // Power-up init command bytes, all sent with RS=0.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h38;
            2'd1:    cmd = 8'h0C;
            2'd2:    cmd = 8'h01;
            default: cmd = 8'h06;
        endcase
        return cmd;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       init_idx_q, init_idx_d;
    pend_t            pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic             on_q, on_d;
    logic             busy_q, busy_d;
    logic             init_done_q, init_done_d;
    logic             ovf_q, ovf_d;

    logic             consume;
    logic             exec_long;
    logic [CNT_W-1:0] wait_lim;
    pend_t            wr_pend;
    logic             unused_wdata;

    assign wr_pend      = '{on: i_lcd_wdata[31], rs: i_lcd_wdata[9], data: i_lcd_wdata[7:0]};
    assign unused_wdata = ^{i_lcd_wdata[30:10], i_lcd_wdata[8]};

    // Clear and return-home commands need the long execution wait.
    assign exec_long = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));
    assign wait_lim  = exec_long ? LIM_LONG : LIM_EXEC;

    // Next-state logic for the bus sequencer, the pending slot and the status flags.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        init_idx_d  = init_idx_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        data_d      = data_q;
        rs_d        = rs_q;
        en_d        = en_q;
        on_d        = on_q;
        init_done_d = init_done_q;
        ovf_d       = ovf_q;
        consume     = 1'b0;

        case (state_q)
            S_PWRUP: begin
                on_d = 1'b1;
                if (cnt_q == LIM_PWRUP) begin
                    state_d    = S_SETUP;
                    cnt_d      = '0;
                    rs_d       = 1'b0;
                    data_d     = init_cmd(init_idx_q[1:0]);
                    init_idx_d = init_idx_q + 3'd1;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (pend_vld_q) begin
                    consume = 1'b1;
                    state_d = S_SETUP;
                    rs_d    = pend_q.rs;
                    data_d  = pend_q.data;
                    on_d    = pend_q.on;
                end
            end
            S_SETUP: begin
                if (cnt_q == LIM_SU) begin
                    state_d = S_PULSE;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt_q == LIM_EN) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                end
            end
            S_HOLD: begin
                if (cnt_q == LIM_HOLD) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_lim) begin
                    cnt_d = '0;
                    if (init_idx_q < INIT_LEN) begin
                        // Chain straight into the next init step without visiting IDLE.
                        state_d    = S_SETUP;
                        rs_d       = 1'b0;
                        data_d     = init_cmd(init_idx_q[1:0]);
                        init_idx_d = init_idx_q + 3'd1;
                    end else begin
                        state_d     = S_IDLE;
                        init_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_PWRUP;
                cnt_d   = '0;
                en_d    = 1'b0;
            end
        endcase

        // A slot being consumed this cycle is free for a write on the same edge.
        if (consume) begin
            pend_vld_d = 1'b0;
        end
        if (i_lcd_we) begin
            if (!pend_vld_q || consume) begin
                pend_d     = wr_pend;
                pend_vld_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE) || pend_vld_d;
    end

    // State and output registers; reset drops EN and power immediately.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_PWRUP;
            cnt_q       <= '0;
            init_idx_q  <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            data_q      <= '0;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            on_q        <= 1'b0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            en_q        <= en_d;
            on_q        <= on_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign o_lcd_data  = data_q;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_en    = en_q;
    assign o_lcd_on    = on_q;
    assign o_busy      = busy_q;
    assign o_init_done = init_done_q;
    assign o_ovf       = ovf_q;

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Downstream consumer of the output-peripheral memory's LCD register (address 0x7030).
- Converts each CPU write to that register into one correctly timed HD44780-style write cycle on the character-LCD pins.
- Runs the LCD power-up initialisation sequence autonomously after reset.
- Exposes busy / init-done / overflow status so software can poll before issuing the next command.

Parameters:
T_PWRUP, 750000, cycles to wait after reset release before the first init command (15 ms @ 50 MHz)
T_SU, 4, cycles RS/DATA are stable before EN rises
T_EN, 12, cycles EN is held high
T_HOLD, 2, cycles RS/DATA are held after EN falls
T_EXEC, 1850, post-command wait for normal commands/data (37 us)
T_EXEC_LONG, 76000, post-command wait for clear/home (1.52 ms)
CNT_W, 20, width of the shared delay counter; must hold max(T_PWRUP, T_EXEC_LONG)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-low reset
i_lcd_we  in  1  one-cycle strobe: store to the LCD register decoded this cycle
i_lcd_wdata  in  32  store data: [31]=LCD_ON, [9]=RS, [7:0]=DATA; other bits ignored
o_lcd_data  out  8  LCD data bus
o_lcd_rs  out  1  register select (0 = command, 1 = data)
o_lcd_rw  out  1  read/write; tied 0 (write-only)
o_lcd_en  out  1  enable strobe
o_lcd_on  out  1  LCD power/backlight enable
o_busy  out  1  command in flight or pending
o_init_done  out  1  init sequence complete
o_ovf  out  1  sticky: a write was dropped

Behaviour:
- Reset is asynchronous and active-low: i_rst=0 asynchronously forces all of the following.
  - Outputs: o_lcd_data=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0, o_busy=1, o_init_done=0, o_ovf=0.
  - Internal: pending buffer empty, init index 0, FSM=PWRUP, counter 0.
- FSM states: PWRUP, IDLE, SETUP, PULSE, HOLD, WAIT.
  - PWRUP: o_lcd_on=1. Counts T_PWRUP cycles, then issues init command 0.
  - Issue (IDLE->SETUP, or PWRUP/WAIT->SETUP for an init step): on the issuing edge, drive RS/DATA and load the counter. EN stays 0.
  - SETUP: T_SU cycles, then PULSE.
  - PULSE: EN=1 for exactly T_EN cycles, then HOLD.
  - HOLD: EN=0 and RS/DATA unchanged for T_HOLD cycles, then WAIT.
  - WAIT: lasts T_EXEC_LONG cycles if RS=0 and DATA is in {0x01, 0x02, 0x03}; otherwise T_EXEC cycles. Exits to the next init command, or to IDLE.
- Init sequence: RS=0 with DATA 0x38, 0x0C, 0x01, 0x06, in that order.
  - o_init_done rises on the edge WAIT of the 4th init command exits to IDLE, and stays 1 until reset.
- User writes and the pending buffer (1 entry holding ON, RS, DATA):
  - i_lcd_we=1 with the buffer empty: captures i_lcd_wdata on that edge, in any state, including PWRUP/init.
  - i_lcd_we=1 with the buffer full: the write is dropped and o_ovf is set to 1 (sticky until reset).
  - Same cycle as the buffer is consumed: the new write is accepted into the freed slot; no overflow.
- Issuing user commands: in IDLE with the buffer full, the next edge issues the buffered command.
  - Buffer is cleared, o_lcd_on is updated from buffered bit 31, and the FSM enters SETUP.
  - Latency: write strobe at edge N -> RS/DATA driven at edge N+1 -> EN rises at edge N+1+T_SU.
- o_busy = (state != IDLE) OR buffer full, registered. It is 0 only when IDLE and the buffer is empty.
- o_lcd_rw is constant 0. No readback of the LCD busy flag; all pacing is by timers.
- Reset asserted mid-operation: EN drops immediately (asynchronous). On release, the full init sequence reruns from PWRUP.

Test Plan (parameters T_PWRUP=20, T_SU=2, T_EN=4, T_HOLD=1, T_EXEC=10, T_EXEC_LONG=30):
1. Release reset, no writes.
   -> After 20 cycles, 4 EN pulses, each 4 cycles wide, with RS=0 and DATA 0x38, 0x0C, 0x01, 0x06.
   -> Gap after 0x01 is 30 WAIT cycles; the others are 10.
   -> o_init_done=1 after the last WAIT; o_busy=0; o_lcd_on=1.
2. After init, write 0x8000_0241 (ON=1, RS=1, DATA=0x41).
   -> RS=1 and DATA=0x41 on the next edge; EN high 2 cycles later for 4 cycles.
   -> o_busy high for 1+2+4+1+10 cycles, then 0.
3. Write RS=0, DATA=0x01 after init.
   -> WAIT is 30 cycles.
   -> A second write (0x0000_0002) arriving during that WAIT is issued exactly when the WAIT ends; its own WAIT is also 30 cycles.
4. During the EN pulse of a command, write A (buffered), then B one cycle later.
   -> A is issued after the current command; B is dropped; o_ovf=1.
   -> o_ovf stays 1 across later successful commands.
5. Write 0x0000_0248 during PWRUP.
   -> Held in the buffer; issued immediately after the 4th init WAIT; o_lcd_on becomes 0 (bit 31=0).
6. Assert i_rst while EN=1.
   -> o_lcd_en, o_lcd_on, o_ovf and o_init_done go to 0 without waiting for a clock edge.
   -> After release, the init sequence restarts with DATA 0x38 after 20 cycles.
